// File: rtl/memdata_pkg.sv
// Shared types and default sizing for the wait-stated data memory (memdata_ws).
package memdata_pkg;

    typedef enum logic {IDLE, BUSY} state_t;
    typedef enum logic {OP_RD, OP_WR} op_t;

    localparam int DATA_W_DEF      = 8;
    localparam int ADDR_W_DEF      = 14;
    localparam int DEPTH_DEF       = 12288;
    localparam int WAIT_STATES_DEF = 2;

endpackage

// File: rtl/memdata_ws_ctrl.sv
// Access controller for memdata_ws: FSM, wait counter, request latches, ready/err pulses.
// Exposes its state so the top can derive busy and checkers can observe the FSM.
module memdata_ctrl
    import memdata_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] dir,
    input  logic [DATA_W-1:0] indata,
    input  logic              parity_err,
    output op_t               op_q,
    output logic [ADDR_W-1:0] dir_q,
    output logic [DATA_W-1:0] data_q,
    output logic              in_range,
    output logic              done,
    output logic              ready,
    output logic              err,
    output state_t            state
);

    localparam int CNT_W = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_STATES);
    localparam logic [ADDR_W:0]  DEPTH_L  = (ADDR_W + 1)'(DEPTH);

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    assign state    = state_q;
    assign in_range = ({1'b0, dir_q} < DEPTH_L);

    // Handshake: a request (cs with we or oe) is taken only in IDLE; busy stays
    // high until completion, and ready/err pulse for the single following cycle.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs && (we || oe)) begin
                    accept  = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= OP_RD;
            dir_q   <= '0;
            data_q  <= '0;
            ready   <= 1'b0;
            err     <= 1'b0;
        end else begin
            state_q <= state_d;
            ready   <= done;
            err     <= done && (!in_range || (op_q == OP_RD && parity_err));
            if (accept) begin
                op_q   <= we ? OP_WR : OP_RD;
                dir_q  <= dir;
                data_q <= indata;
                cnt_q  <= CNT_INIT;
            end else if (state_q == BUSY && cnt_q != '0) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

endmodule

// File: rtl/memdata_ws.sv
// Wait-stated data memory with tri-state read bus and busy/ready handshake.
// Optional stored even parity per word when MEMDATA_PARITY_EN is defined.
module memdata_ws
    import memdata_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DEPTH       = DEPTH_DEF,
    parameter int WAIT_STATES = WAIT_STATES_DEF
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic              oe,
    input  logic [ADDR_W-1:0] dir,
    input  logic [DATA_W-1:0] indata,
    output logic [DATA_W-1:0] outdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

`ifdef MEMDATA_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0]  mem [DEPTH];
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic [DATA_W-1:0] rdata_q;
    logic              parity_err;
    op_t               op_q;
    logic [ADDR_W-1:0] dir_q;
    logic [DATA_W-1:0] data_q;
    logic              in_range;
    logic              done;
    state_t            ctrl_state;

    memdata_ctrl #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WAIT_STATES)
    ) u_ctrl (
        .clk        (clk),
        .reset_n    (reset_n),
        .cs         (cs),
        .we         (we),
        .oe         (oe),
        .dir        (dir),
        .indata     (indata),
        .parity_err (parity_err),
        .op_q       (op_q),
        .dir_q      (dir_q),
        .data_q     (data_q),
        .in_range   (in_range),
        .done       (done),
        .ready      (ready),
        .err        (err),
        .state      (ctrl_state)
    );

    assign busy    = (ctrl_state == BUSY);
    assign rd_word = in_range ? mem[dir_q] : '0;

`ifdef MEMDATA_PARITY_EN
    assign wr_word    = {^data_q, data_q};
    assign parity_err = in_range && (^rd_word);
`else
    assign wr_word    = data_q;
    assign parity_err = 1'b0;
`endif

    // Gated by reset_n so a reset landing on the completion edge aborts the write.
    always_ff @(posedge clk) begin
        if (reset_n && done && op_q == OP_WR && in_range) begin
            mem[dir_q] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rdata_q <= '0;
        end else if (done && op_q == OP_RD) begin
            rdata_q <= rd_word[DATA_W-1:0];
        end
    end

    assign outdata = (cs && oe) ? rdata_q : 'z;

endmodule

// File: tb/tb_memdata_ws.sv
// Directed self-checking bench for memdata_ws (WAIT_STATES=2 and WAIT_STATES=0 instances).
module tb_memdata_ws;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       cs = 1'b0, we = 1'b0, oe = 1'b0;
    logic [13:0] dir = '0;
    logic [7:0] indata = '0;
    wire  [7:0] outdata;
    logic       ready, busy, err;

    logic       cs0 = 1'b0, we0 = 1'b0, oe0 = 1'b0;
    logic [13:0] dir0 = '0;
    logic [7:0] indata0 = '0;
    wire  [7:0] outdata0;
    logic       ready0, busy0, err0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Undriven bus bits read as 1, so a released bus shows up as 0xFF.
    for (genvar i = 0; i < 8; i++) begin : g_pull
        pullup (outdata[i]);
        pullup (outdata0[i]);
    end

    memdata_ws #(.DATA_W(8), .ADDR_W(14), .DEPTH(12288), .WAIT_STATES(2)) dut (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .oe(oe), .dir(dir),
        .indata(indata), .outdata(outdata), .ready(ready), .busy(busy), .err(err)
    );

    memdata_ws #(.DATA_W(8), .ADDR_W(14), .DEPTH(12288), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .cs(cs0), .we(we0), .oe(oe0), .dir(dir0),
        .indata(indata0), .outdata(outdata0), .ready(ready0), .busy(busy0), .err(err0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output logic e);
        logic got;
        got = 1'b0;
        e   = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            tick();
            if (ready) begin
                got = 1'b1;
                e   = err;
            end
        end
        if (!got) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_write(input logic [13:0] a, input logic [7:0] d, output logic e);
        cs = 1'b1; we = 1'b1; oe = 1'b0; dir = a; indata = d;
        tick();
        cs = 1'b0; we = 1'b0;
        wait_ready(e);
    endtask

    task automatic do_read(input logic [13:0] a, output logic e, output logic [7:0] d);
        cs = 1'b1; we = 1'b0; oe = 1'b1; dir = a;
        tick();
        cs = 1'b0; oe = 1'b0;
        wait_ready(e);
        cs = 1'b1; oe = 1'b1;
        #1 d = outdata;
        cs = 1'b0; oe = 1'b0;
    endtask

    initial begin
        logic       e;
        logic [7:0] d;
        int         busy_n, ready_n, ready_at;
        logic [7:0] rpat, bpat;

        repeat (3) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_ready", ready, 1'b0);
        check("rst_err", err, 1'b0);
        cs = 1'b1; oe = 1'b0;
        #1 check("rst_bus_released", outdata, 8'hFF);
        oe = 1'b1;
        #1 check("rst_rdata_zero", outdata, 8'h00);
        cs = 1'b0; oe = 1'b0;
        reset_n = 1'b1;
        tick();

        // Write 0xA5 to 0x005 and watch the busy window and ready pulse.
        cs = 1'b1; we = 1'b1; dir = 14'h005; indata = 8'hA5;
        tick();
        cs = 1'b0; we = 1'b0;
        busy_n = 0; ready_n = 0; ready_at = -1;
        for (int i = 0; i < 6; i++) begin
            if (busy) busy_n++;
            if (ready) begin
                ready_n++;
                ready_at = i;
            end
            tick();
        end
        check("wr_busy_cycles", busy_n, 3);
        check("wr_ready_pulses", ready_n, 1);
        check("wr_ready_at", ready_at, 3);

        cs = 1'b1; oe = 1'b1; dir = 14'h005;
        tick();
        cs = 1'b0; oe = 1'b0;
        wait_ready(e);
        check("rd_err", e, 1'b0);
        cs = 1'b1; oe = 1'b1;
        #1 check("rd_data_ready_cycle", outdata, 8'hA5);
        cs = 1'b0; oe = 1'b0;
        tick();
        cs = 1'b1; oe = 1'b1;
        #1 check("rd_data_after_ready", outdata, 8'hA5);
        cs = 1'b0; oe = 1'b0;

        // Back-to-back writes with zero wait states: one accept every 2 cycles.
        cs0 = 1'b1; we0 = 1'b1;
        for (int c = 0; c < 8; c++) begin
            dir0 = 14'(c); indata0 = 8'h40 + 8'(c);
            tick();
            rpat[c] = ready0;
            bpat[c] = busy0;
        end
        cs0 = 1'b0; we0 = 1'b0;
        check("ws0_ready_pattern", rpat, 8'hAA);
        check("ws0_busy_pattern", bpat, 8'h55);
        for (int k = 0; k < 2; k++) begin
            cs0 = 1'b1; oe0 = 1'b1; dir0 = (k == 0) ? 14'd2 : 14'd6;
            tick();
            cs0 = 1'b0; oe0 = 1'b0;
            tick();
            check("ws0_rd_ready", ready0, 1'b1);
            cs0 = 1'b1; oe0 = 1'b1;
            #1 check("ws0_rd_data", outdata0, (k == 0) ? 8'h42 : 8'h46);
            cs0 = 1'b0; oe0 = 1'b0;
        end

        // Out-of-range read clears the read register and flags err.
        do_read(14'd12288, e, d);
        check("oor_rd_err", e, 1'b1);
        check("oor_rd_data", d, 8'h00);

        // Last legal word, and a dropped out-of-range write that must not alias.
        do_write(14'd12287, 8'h5A, e);
        check("top_wr_err", e, 1'b0);
        do_read(14'd12287, e, d);
        check("top_rd_data", d, 8'h5A);
        do_write(14'h2C8, 8'h11, e);
        do_write(14'd13000, 8'hEE, e);
        check("oor_wr_err", e, 1'b1);
        do_read(14'h2C8, e, d);
        check("oor_wr_no_alias", d, 8'h11);

        // Inputs changing during BUSY are ignored, including cs dropping.
        do_write(14'h020, 8'h99, e);
        cs = 1'b1; we = 1'b1; dir = 14'h010; indata = 8'h3C;
        tick();
        cs = 1'b0; dir = 14'h020; indata = 8'hFF;
        wait_ready(e);
        we = 1'b0;
        do_read(14'h010, e, d);
        check("midop_target", d, 8'h3C);
        do_read(14'h020, e, d);
        check("midop_other", d, 8'h99);

        // Reset one cycle after accepting a write aborts it.
        do_write(14'h030, 8'h42, e);
        cs = 1'b1; we = 1'b1; dir = 14'h030; indata = 8'h77;
        tick();
        cs = 1'b0; we = 1'b0;
        reset_n = 1'b0;
        tick();
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ready", ready, 1'b0);
        reset_n = 1'b1;
        cs = 1'b1; oe = 1'b0;
        #1 check("rstmid_bus_released", outdata, 8'hFF);
        oe = 1'b1;
        #1 check("rstmid_rdata_zero", outdata, 8'h00);
        cs = 1'b0; oe = 1'b0;
        ready_n = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (ready) ready_n++;
        end
        check("rstmid_no_ready", ready_n, 0);
        do_read(14'h030, e, d);
        check("rstmid_mem_kept", d, 8'h42);

`ifdef MEMDATA_PARITY_EN
        do_write(14'h040, 8'h81, e);
        dut.mem[64][8] = ~dut.mem[64][8];
        do_read(14'h040, e, d);
        check("parity_err", e, 1'b1);
        check("parity_data", d, 8'h81);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 32'd0, 32'd1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
